// File: rtl/rv_pipe_pkg.sv
// Shared RV32 pipeline definitions: opcodes, hazard-controller state encoding,
// the pipeline-register control bundle and the NOP that bubbles turn into.
package rv_pipe_pkg;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;

    // addi x0, x0, 0 -- what a flushed/bubbled stage register holds.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_FREEZE = '{default: 1'b0};

    localparam ctrl_out_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
        id_ex_en: 1'b0, id_ex_bubble: 1'b1, ex_mem_en: 1'b0
    };

    // Control while the pipe is allowed to advance. A taken branch beats a
    // load-use hazard because the dependent instruction is on the wrong path.
    function automatic ctrl_out_t flow_ctrl(input logic branch_taken, input logic load_use);
        ctrl_out_t c;
        c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
              id_ex_en: 1'b1, id_ex_bubble: 1'b0, ex_mem_en: 1'b1};
        if (branch_taken) begin
            c.if_id_flush  = 1'b1;
            c.id_ex_bubble = 1'b1;
        end else if (load_use) begin
            c.pc_en        = 1'b0;
            c.if_id_en     = 1'b0;
            c.id_ex_bubble = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();

    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_valid;
    logic             ex_write_enable;
    logic [4:0]       ex_rd_sel;
    logic [6:0]       ex_opcode;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_bubble;
    logic             ex_mem_en;
    logic             mem_fault;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_write_enable, ex_rd_sel, ex_opcode, ex_branch_taken,
        output mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
        input  mem_fault, ctrl_state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_write_enable, ex_rd_sel, ex_opcode, ex_branch_taken,
        input  mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
        output mem_fault, ctrl_state, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a valid load in EX writing a register that
// the valid decode-stage instruction reads.
module load_use_detect
    import rv_pipe_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_write_enable,
    input  logic [4:0] ex_rd_sel,
    input  logic [6:0] ex_opcode,
    output logic       load_use
);

    logic       ex_is_load;
    logic [4:0] src_sel [2];
    logic [1:0] src_used;
    logic [1:0] src_hit;

    // x0 is never a real destination, so a load into it cannot create a hazard.
    assign ex_is_load = ex_valid && ex_write_enable && (ex_opcode == OP_LOAD)
                        && (ex_rd_sel != 5'd0);

    assign src_sel[0] = id_rs1;
    assign src_sel[1] = id_rs2;
    assign src_used   = {id_uses_rs2, id_uses_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_sel[gi] == ex_rd_sel);
        end
    endgenerate

    assign load_use = ex_is_load && id_valid && (|src_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubbles, branch flushes,
// data-memory freeze with timeout escalation to a sticky fault.
module pipeline_hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int WAIT_W = 16;

    ctrl_state_t       state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              mem_fault_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  flush_cnt_reg;

    logic      load_use;
    logic      mem_stall;
    logic      flow_path;
    logic      stall_inc;
    logic      flush_inc;
    ctrl_out_t ctrl;

    load_use_detect u_lu (
        .id_valid        (bus.id_valid),
        .id_rs1          (bus.id_rs1),
        .id_rs2          (bus.id_rs2),
        .id_uses_rs1     (bus.id_uses_rs1),
        .id_uses_rs2     (bus.id_uses_rs2),
        .ex_valid        (bus.ex_valid),
        .ex_write_enable (bus.ex_write_enable),
        .ex_rd_sel       (bus.ex_rd_sel),
        .ex_opcode       (bus.ex_opcode),
        .load_use        (load_use)
    );

    assign mem_stall = bus.mem_req && !bus.mem_ready;

    // flow_path: the pipe may advance this cycle (branch/hazard/normal decide how).
    always_comb begin
        ctrl      = CTRL_FREEZE;
        flow_path = 1'b0;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state_reg)
                ST_RUN:      flow_path = !mem_stall;
                ST_MEM_WAIT: flow_path = bus.mem_ready;
                default:     flow_path = 1'b0;
            endcase
            if (flow_path) begin
                ctrl = flow_ctrl(bus.ex_branch_taken, load_use);
            end
        end
    end

    assign stall_inc = !rst && ((state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT))
                       && !ctrl.pc_en;
    assign flush_inc = flow_path && bus.ex_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            mem_fault_reg <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_stall) begin
                        state_reg    <= ST_MEM_WAIT;
                        wait_cnt_reg <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state_reg    <= ST_RUN;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_reg     <= ST_FAULT;
                        mem_fault_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                default: state_reg <= ST_FAULT;
            endcase

            // Performance counters stick at all-ones instead of wrapping.
            if (stall_inc && !(&stall_cnt_reg)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (flush_inc && !(&flush_cnt_reg)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.id_ex_bubble = ctrl.id_ex_bubble;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_fault    = mem_fault_reg;
    assign bus.ctrl_state   = state_reg;
    assign bus.stall_cnt    = stall_cnt_reg;
    assign bus.flush_cnt    = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-cycle expected outputs come
// from a behavioural model, are queued when driven and compared at negedge.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam logic [6:0] LOAD_OPC = 7'b0000011;
    localparam logic [6:0] ALU_OPC  = 7'b0110011;

    logic clk = 1'b0;
    logic rst;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       u1;
        logic       u2;
        logic       ex_valid;
        logic       ex_we;
        logic [4:0] ex_rd;
        logic [6:0] op;
        logic       br;
        logic       mreq;
        logic       mrdy;
    } stim_t;

    // ctrl bits: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en}
    typedef struct packed {
        logic [5:0]       ctrl;
        logic [1:0]       state;
        logic             fault;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_state, m_wait, m_stall, m_flush;
    bit m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.id_valid = 1'b1;
        s.op       = ALU_OPC;
        return s;
    endfunction

    function automatic stim_t load_in_ex(input logic [4:0] rd);
        stim_t s;
        s = idle();
        s.ex_valid = 1'b1;
        s.ex_we    = 1'b1;
        s.ex_rd    = rd;
        s.op       = LOAD_OPC;
        return s;
    endfunction

    task automatic apply(input stim_t s, input string name, input bit verbose);
        exp_t       e;
        exp_t       got_e;
        logic [5:0] c;
        bit         lu, flow;

        rst                 = s.rst;
        bus.id_valid        = s.id_valid;
        bus.id_rs1          = s.id_rs1;
        bus.id_rs2          = s.id_rs2;
        bus.id_uses_rs1     = s.u1;
        bus.id_uses_rs2     = s.u2;
        bus.ex_valid        = s.ex_valid;
        bus.ex_write_enable = s.ex_we;
        bus.ex_rd_sel       = s.ex_rd;
        bus.ex_opcode       = s.op;
        bus.ex_branch_taken = s.br;
        bus.mem_req         = s.mreq;
        bus.mem_ready       = s.mrdy;

        lu = s.ex_valid && s.ex_we && (s.op == LOAD_OPC) && (s.ex_rd != 5'd0) && s.id_valid
             && ((s.u1 && s.id_rs1 == s.ex_rd) || (s.u2 && s.id_rs2 == s.ex_rd));
        flow = 1'b0;
        c    = 6'b000000;
        if (s.rst)             c = 6'b001010;
        else if (m_state == 0) flow = !(s.mreq && !s.mrdy);
        else if (m_state == 1) flow = s.mrdy;
        if (flow) begin
            if (s.br)    c = 6'b111111;
            else if (lu) c = 6'b000111;
            else         c = 6'b110101;
        end

        e.ctrl  = c;
        e.state = m_state[1:0];
        e.fault = m_fault;
        e.stall = m_stall[CNT_W-1:0];
        e.flush = m_flush[CNT_W-1:0];
        exp_q.push_back(e);

        if (s.rst) begin
            m_state = 0; m_wait = 0; m_fault = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_state != 2) begin
                if (!c[5] && m_stall < CNT_MAX) m_stall++;
                if (flow && s.br && m_flush < CNT_MAX) m_flush++;
            end
            if (m_state == 0) begin
                if (s.mreq && !s.mrdy) begin m_state = 1; m_wait = 1; end
            end else if (m_state == 1) begin
                if (s.mrdy) begin
                    m_state = 0; m_wait = 0;
                end else if (m_wait == MEM_TIMEOUT - 1) begin
                    m_state = 2; m_fault = 1;
                end else begin
                    m_wait++;
                end
            end
        end

        @(negedge clk);
        got_e.ctrl  = {bus.pc_en, bus.if_id_en, bus.if_id_flush,
                       bus.id_ex_en, bus.id_ex_bubble, bus.ex_mem_en};
        got_e.state = bus.ctrl_state;
        got_e.fault = bus.mem_fault;
        got_e.stall = bus.stall_cnt;
        got_e.flush = bus.flush_cnt;
        e = exp_q.pop_front();
        check({name, ".ctrl"},  32'(got_e.ctrl),  32'(e.ctrl));
        check({name, ".state"}, 32'(got_e.state), 32'(e.state));
        check({name, ".fault"}, 32'(got_e.fault), 32'(e.fault));
        check({name, ".stall"}, 32'(got_e.stall), 32'(e.stall));
        check({name, ".flush"}, 32'(got_e.flush), 32'(e.flush));
        if (verbose)
            $display("[TB] %-10s ctrl=%06b st=%0d fault=%0b stall=%0d flush=%0d",
                     name, got_e.ctrl, got_e.state, got_e.fault, got_e.stall, got_e.flush);
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;

        s = idle();
        s.rst = 1'b1;
        rst = 1'b1;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0;
        bus.id_uses_rs2 = 0; bus.ex_valid = 0; bus.ex_write_enable = 0; bus.ex_rd_sel = 0;
        bus.ex_opcode = 0; bus.ex_branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
        m_state = 0; m_wait = 0; m_fault = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;

        apply(s, "reset", 1);
        apply(s, "reset", 1);
        apply(idle(), "idle", 1);

        // lw x5 in EX, decode reads x5 on rs1: one bubble then normal flow
        s = load_in_ex(5'd5); s.u1 = 1; s.id_rs1 = 5'd5;
        apply(s, "lu_rs1", 1);
        apply(idle(), "after_lu", 1);
        // rs2 dependency
        s = load_in_ex(5'd7); s.u2 = 1; s.id_rs2 = 5'd7; s.id_rs1 = 5'd3; s.u1 = 1;
        apply(s, "lu_rs2", 1);
        // no hazard: rd=x0, unused sources, invalid decode, non-load
        s = load_in_ex(5'd0); s.u1 = 1; s.id_rs1 = 5'd0;
        apply(s, "lu_x0", 1);
        s = load_in_ex(5'd5); s.id_rs1 = 5'd5; s.id_rs2 = 5'd5;
        apply(s, "lu_unused", 1);
        s = load_in_ex(5'd5); s.u1 = 1; s.id_rs1 = 5'd5; s.id_valid = 0;
        apply(s, "lu_idinv", 1);
        s = load_in_ex(5'd5); s.u1 = 1; s.id_rs1 = 5'd5; s.op = ALU_OPC;
        apply(s, "not_load", 1);

        // branch overrides load-use
        s = load_in_ex(5'd5); s.u1 = 1; s.id_rs1 = 5'd5; s.br = 1;
        apply(s, "br_lu", 1);
        apply(idle(), "idle", 1);

        // three frozen cycles then ready
        s = idle(); s.mreq = 1;
        repeat (3) apply(s, "mem_wait", 1);
        s.mrdy = 1;
        apply(s, "mem_ready", 1);
        apply(idle(), "idle", 1);

        // ready cycle carrying a branch and a load-use bubble
        s = idle(); s.mreq = 1;
        apply(s, "mem_wait", 1);
        s = idle(); s.mreq = 1; s.mrdy = 1; s.br = 1;
        apply(s, "rdy_branch", 1);
        s = idle(); s.mreq = 1;
        apply(s, "mem_wait", 1);
        s = load_in_ex(5'd9); s.u2 = 1; s.id_rs2 = 5'd9; s.mreq = 1; s.mrdy = 1;
        apply(s, "rdy_lu", 1);

        // timeout escalation, sticky fault, cleared only by reset
        s = idle(); s.mreq = 1;
        repeat (6) apply(s, "timeout", 1);
        s.mrdy = 1; s.br = 1;
        repeat (2) apply(s, "fault_hold", 1);
        s = idle(); s.rst = 1;
        apply(s, "fault_rst", 1);
        apply(idle(), "idle", 1);

        // reset in the middle of a memory wait
        s = idle(); s.mreq = 1;
        repeat (2) apply(s, "mem_wait", 1);
        s.rst = 1;
        apply(s, "wait_rst", 1);
        apply(idle(), "idle", 1);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            s = '0;
            s.rst      = ($urandom_range(0, 19) == 0);
            s.id_valid = $urandom_range(0, 3) != 0;
            s.id_rs1   = 5'($urandom_range(0, 3));
            s.id_rs2   = 5'($urandom_range(0, 3));
            s.u1       = $urandom_range(0, 1) == 1;
            s.u2       = $urandom_range(0, 1) == 1;
            s.ex_valid = $urandom_range(0, 3) != 0;
            s.ex_we    = $urandom_range(0, 3) != 0;
            s.ex_rd    = 5'($urandom_range(0, 3));
            s.op       = ($urandom_range(0, 1) == 1) ? LOAD_OPC : ALU_OPC;
            s.br       = ($urandom_range(0, 5) == 0);
            s.mreq     = ($urandom_range(0, 2) == 0);
            s.mrdy     = $urandom_range(0, 1) == 1;
            apply(s, "random", 0);
        end

        // hold a load-use hazard long enough to saturate the stall counter
        s = idle(); s.rst = 1;
        apply(s, "reset", 1);
        s = load_in_ex(5'd5); s.u1 = 1; s.id_rs1 = 5'd5;
        for (int i = 0; i < CNT_MAX + 3; i++) apply(s, "sat", 0);
        apply(s, "sat_end", 1);
        check("stall_sat", 32'(bus.stall_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
